serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add/subtract sequencer that time-shares a single full-adder cell (two `add_half` instances plus an OR for the carry) across all bit positions of a WIDTH-bit operation. It latches two operands on a start request, then feeds one bit pair per clock through the shared cell while holding the running carry in a flop. On completion it returns a registered result, carry and signed-overflow flag with a one-cycle done pulse. The block serves as the low-area arithmetic unit next to the MIPS datapath for auxiliary address and counter computations.

## Interface
- `WIDTH`, 32, operand/result width in bits; minimum 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op_a`  in  WIDTH  first operand, latched when `start` is accepted.
- `op_b`  in  WIDTH  second operand, latched when `start` is accepted.
- `sub`  in  1  1 = compute `op_a - op_b`; latched with the operands.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  one-cycle pulse; `result`/`carry_out`/`overflow` are valid.
- `result`  out  WIDTH  sum or difference, held until the next completion.
- `carry_out`  out  1  carry out of the MSB; for subtraction, 1 = no borrow.
- `overflow`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: `busy`=0, `done`=0, `result`=0, `carry_out`=0, `overflow`=0, bit counter=0, carry flop=0.
- IDLE or DONE with `start`=1:
  - Latch `op_a` into shift register A.
  - Latch `op_b` (bitwise inverted if `sub`) into shift register B.
  - Set carry flop = `sub`, counter = 0. Go to RUN.
- IDLE or DONE with `start`=0: go to or stay in IDLE.
- RUN, each cycle:
  - The shared cell adds A[0], B[0] and the carry flop.
  - The sum bit shifts into the MSB of the result shift register. A and B shift right by one.
  - The carry flop takes the cell carry. The counter increments.
  - On the cycle the counter equals WIDTH-1:
    - Copy the completed shift register (including this bit) to `result`.
    - `carry_out` takes the cell carry.
    - `overflow` = carry flop (carry into MSB) XOR cell carry.
    - Go to DONE.
- DONE: `done`=1 for exactly this cycle. Next state is IDLE, or RUN if `start`=1 (back-to-back).
- `start` in RUN is ignored. It is not queued, and latched operands are unaffected.
- Operand inputs may change freely after acceptance.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - Counter width is $clog2(WIDTH).
  - No internal value is wider than WIDTH, except the single carry flop.
- `result`, `carry_out` and `overflow` change only on the transition into DONE or on reset.

## Timing
- Edge E0 samples `start`=1 → RUN; `busy`=1 from E0.
- Edges E1..E_WIDTH each process one bit, LSB first.
- At E_WIDTH: outputs update, `busy`=0, `done`=1 until E_WIDTH+1.
- Latency from accepting edge to `done` high is WIDTH edges. Throughput is one operation per WIDTH+1 cycles.
- Back-to-back: `start`=1 while `done`=1 is accepted at that edge, and the next `done` follows WIDTH edges later.
- Reset asserted during RUN:
  - At that edge: IDLE, all outputs zero, and the partial operation is discarded with no `done`.
  - `start` on the reset edge is ignored.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - `sub` is honoured (operand-B inversion, carry-in = 1).
- `SERIAL_ADD_SUB_EN` undefined:
  - The `sub` port remains but is ignored. Every operation is an addition with carry-in 0.
  - The inverter logic is not generated.

## Test plan
WIDTH=8 unless stated.
- `op_a`=0x0F, `op_b`=0x01, `sub`=0 → after 8 edges `done`=1 for one cycle, `result`=0x10, `carry_out`=0, `overflow`=0; `busy` high for exactly 8 cycles.
- 0xFF + 0x01 → `result`=0x00, `carry_out`=1, `overflow`=0. Then 0x7F + 0x01 → `result`=0x80, `carry_out`=0, `overflow`=1.
- `SERIAL_ADD_SUB_EN` defined:
  - 0x05 - 0x07 → `result`=0xFE, `carry_out`=0, `overflow`=0.
  - 0x80 - 0x01 → `result`=0x7F, `carry_out`=1, `overflow`=1.
- `SERIAL_ADD_SUB_EN` undefined: 0x05 with `sub`=1 and `op_b`=0x07 → `result`=0x0C.
- Start 0x10+0x20, then pulse `start` with 0xAA+0x55 at edge E3 → single `done`, `result`=0x30. Reassert `start` during `done` with 0xAA+0x55 → second `done` 8 edges later, `result`=0xFF.
- Start 0x0F+0x01, assert `reset` at E4 → all outputs 0 next cycle and no `done` pulse. Start 0x01+0x01 after release → `result`=0x02.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer sharing one full-adder cell
// Optional feature macro: SERIAL_ADD_SUB_EN (honours sub: inverts op_b, carry-in 1).

module add_half (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cy_q, cy_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic               s1, c1, cell_s, c2, cell_c;
    logic [WIDTH-1:0]   sum_shift;
    logic [WIDTH-1:0]   b_load;
    logic               cin_load;

    // The single shared full adder: two half adders plus an OR for the carry.
    add_half u_h1 (.a_i(a_q[0]), .b_i(b_q[0]), .s_o(s1),     .c_o(c1));
    add_half u_h2 (.a_i(s1),     .b_i(cy_q),   .s_o(cell_s), .c_o(c2));
    assign cell_c    = c1 | c2;
    assign sum_shift = {cell_s, r_q[WIDTH-1:1]};

`ifdef SERIAL_ADD_SUB_EN
    assign b_load   = sub ? ~op_b : op_b;
    assign cin_load = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = op_b;
    assign cin_load   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = b_load;
                    cy_d    = cin_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = sum_shift;
                cy_d  = cell_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d = sum_shift;
                    carry_d  = cell_c;
                    ovf_d    = cy_q ^ cell_c;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl (WIDTH=8)

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start, sub;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] hold;
    logic         prev_done = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .sub(sub), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        int ua, ub, sa, sb, r, sr;
        logic c, v, eff;
`ifdef SERIAL_ADD_SUB_EN
        eff = s;
`else
        eff = 1'b0 & s;
`endif
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (eff) begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub;
            c  = (r > 255);
            sr = sa + sb;
        end
        v = (sr > 127) || (sr < -128);
        model = {W'(r & 255), c, v};
    endfunction

    // Monitor: pops the scoreboard on every done and checks held outputs otherwise.
    initial begin
        hold = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (done) begin
                    if (prev_done) begin
                        checks++; errors++;
                        $display("FAIL done_width: done high two cycles in a row");
                    end
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got result 0x%0h with empty scoreboard", result);
                    end else begin
                        hold = exp_q.pop_front();
                        check("result", int'(result), int'(hold[W+1:2]));
                        check("carry_out", int'(carry_out), int'(hold[1]));
                        check("overflow", int'(overflow), int'(hold[0]));
                    end
                end else if ({result, carry_out, overflow} !== hold) begin
                    checks++; errors++;
                    $display("FAIL held_outputs: got 0x%0h expected 0x%0h",
                             {result, carry_out, overflow}, hold);
                end
                prev_done = done;
            end
        end
    end

    // Called right after the accepting edge (+#1); waits for done and checks latency/busy.
    task automatic wait_done(input int exp_lat);
        int n, busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen = 0;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within 30 cycles");
        end else begin
            check("latency", n - 1, exp_lat);
            check("busy_cycles", busy_cnt, exp_lat);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        start = 1'b1; op_a = a; op_b = b; sub = s;
        exp_q.push_back(model(a, b, s));
        @(posedge clk); #1;
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
        wait_done(W);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_carry", int'(carry_out), 0);
        check("rst_ovf", int'(overflow), 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(8'h0F, 8'h01, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h05, 8'h07, 1'b1);
        run_op(8'h80, 8'h01, 1'b1);

        // start during RUN is ignored; then back-to-back start during done
        @(negedge clk);
        start = 1'b1; op_a = 8'h10; op_b = 8'h20; sub = 1'b0;
        exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
        @(posedge clk); #1 start = 1'b0;
        wait_done(W - 3);
        #1;
        start = 1'b1; op_a = 8'hAA; op_b = 8'h55; sub = 1'b0;
        exp_q.push_back(model(8'hAA, 8'h55, 1'b0));
        @(posedge clk); #1 start = 1'b0;
        wait_done(W);

        // reset at E4 aborts the operation; start on the reset edge is ignored
        @(negedge clk);
        start = 1'b1; op_a = 8'h0F; op_b = 8'h01; sub = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b1; op_a = 8'h33; op_b = 8'h44;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        hold = '0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        check("abort_carry", int'(carry_out), 0);
        check("abort_ovf", int'(overflow), 0);
        repeat (15) @(negedge clk);
        check("abort_idle_busy", int'(busy), 0);
        check("abort_scoreboard_empty", exp_q.size(), 0);
        run_op(8'h01, 8'h01, 1'b0);

        // randomized traffic, mixing back-to-back and gapped operations
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
